// File: rtl/idu_ir_freelist.sv
// Rename free list: 32-entry circular array of physical register numbers with
// alloc/commit/tail pointers. Optional consistency checker under IDU_FREELIST_CHK_EN.
module idu_ir_freelist (
  input  logic       clk,
  input  logic       rst_clk,
  input  logic       rtu_global_flush,
  input  logic       y_idu_ir_stall_ctrl,
  input  logic       alloc_req,
  input  logic       rtu_retire_vld,
  input  logic [5:0] rtu_retire_old_preg,
  output logic       alloc_vld,
  output logic [5:0] alloc_preg,
  output logic       freelist_empty,
  output logic [5:0] free_cnt,
  output logic       freelist_err
);

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned PTR_W  = 6;
  localparam int unsigned PREG_W = 6;

  logic [PREG_W-1:0] fl_q [DEPTH];
  logic [PTR_W-1:0]  alloc_ptr;
  logic [PTR_W-1:0]  commit_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [PTR_W-1:0]  commit_nxt;
  logic [PTR_W-1:0]  alloc_nxt;

  // Wrap bit distinguishes a full list (difference 32) from an empty one (0).
  assign free_cnt       = tail_ptr - alloc_ptr;
  assign freelist_empty = (free_cnt == '0);
  assign alloc_vld      = alloc_req & ~freelist_empty & ~y_idu_ir_stall_ctrl & ~rtu_global_flush;
  assign alloc_preg     = fl_q[alloc_ptr[IDX_W-1:0]];

  // Flush rewinds speculative allocations to the post-retire commit point.
  assign commit_nxt = commit_ptr + PTR_W'(rtu_retire_vld);
  assign alloc_nxt  = rtu_global_flush ? commit_nxt : alloc_ptr + PTR_W'(alloc_vld);

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      alloc_ptr  <= '0;
      commit_ptr <= '0;
      tail_ptr   <= PTR_W'(DEPTH);
    end else begin
      alloc_ptr  <= alloc_nxt;
      commit_ptr <= commit_nxt;
      tail_ptr   <= tail_ptr + PTR_W'(rtu_retire_vld);
    end
  end

  // Released pregs are appended at the tail; reset loads pregs 32..63.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fl_q[i] <= PREG_W'(DEPTH + i);
      end
    end else if (rtu_retire_vld) begin
      fl_q[tail_ptr[IDX_W-1:0]] <= rtu_retire_old_preg;
    end
  end

`ifdef IDU_FREELIST_CHK_EN
  logic [PTR_W-1:0] occ;

  assign occ = tail_ptr - commit_ptr;

  // Sticky: retire into a full list or a broken tail/commit relationship.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      freelist_err <= 1'b0;
    end else if (rtu_retire_vld && ((free_cnt == PTR_W'(DEPTH)) || (occ != PTR_W'(DEPTH)))) begin
      freelist_err <= 1'b1;
    end
  end
`else
  assign freelist_err = 1'b0;
`endif

endmodule

// File: tb/tb_idu_ir_freelist.sv
// Scoreboard bench for idu_ir_freelist: queue-based reference model of free and
// speculatively allocated pregs; a negedge monitor compares DUT outputs.
module tb_idu_ir_freelist;

  logic       clk;
  logic       rst_clk;
  logic       rtu_global_flush;
  logic       y_idu_ir_stall_ctrl;
  logic       alloc_req;
  logic       rtu_retire_vld;
  logic [5:0] rtu_retire_old_preg;
  logic       alloc_vld;
  logic [5:0] alloc_preg;
  logic       freelist_empty;
  logic [5:0] free_cnt;
  logic       freelist_err;

  idu_ir_freelist dut (
    .clk                 (clk),
    .rst_clk             (rst_clk),
    .rtu_global_flush    (rtu_global_flush),
    .y_idu_ir_stall_ctrl (y_idu_ir_stall_ctrl),
    .alloc_req           (alloc_req),
    .rtu_retire_vld      (rtu_retire_vld),
    .rtu_retire_old_preg (rtu_retire_old_preg),
    .alloc_vld           (alloc_vld),
    .alloc_preg          (alloc_preg),
    .freelist_empty      (freelist_empty),
    .free_cnt            (free_cnt),
    .freelist_err        (freelist_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       full;
    bit       vld;
    bit [5:0] preg;
    bit [5:0] cnt;
    bit       empty;
    bit       err;
  } exp_t;

  exp_t sb[$];
  int   free_q[$];
  int   spec_q[$];
  bit   m_err;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("freelist_err", freelist_err, e.err);
      if (e.full) begin
        chk("alloc_vld", alloc_vld, e.vld);
        chk("free_cnt", free_cnt, e.cnt);
        chk("freelist_empty", freelist_empty, e.empty);
        if (e.vld) chk("alloc_preg", alloc_preg, e.preg);
      end
    end
  end

  function automatic void model_reset();
    free_q.delete();
    spec_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
    m_err = 1'b0;
  endfunction

  task automatic drive(input bit req, input bit stall, input bit flush, input bit ret,
                       input logic [5:0] old);
    alloc_req           = req;
    y_idu_ir_stall_ctrl = stall;
    rtu_global_flush    = flush;
    rtu_retire_vld      = ret;
    rtu_retire_old_preg = old;
  endtask

  // One normal cycle: push expectation, then advance the model at the edge.
  task automatic step(input bit req, input bit stall, input bit flush, input bit ret,
                      input logic [5:0] old, input bit full = 1'b1);
    exp_t e;
    int   a;
    drive(req, stall, flush, ret, old);
    e.full  = full;
    e.vld   = req && (free_q.size() > 0) && !stall && !flush;
    e.preg  = (free_q.size() > 0) ? 6'(free_q[0]) : 6'd0;
    e.cnt   = 6'(free_q.size());
    e.empty = (free_q.size() == 0);
    e.err   = m_err;
    sb.push_back(e);
    @(posedge clk);
`ifdef IDU_FREELIST_CHK_EN
    if (ret && free_q.size() == 32) m_err = 1'b1;
`endif
    a = 0;
    if (e.vld) a = free_q.pop_front();
    if (ret) begin
      if (spec_q.size() > 0) void'(spec_q.pop_front());
      free_q.push_back(int'(old));
    end
    if (e.vld) spec_q.push_back(a);
    if (flush) begin
      while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
    end
    #1;
  endtask

  // Asynchronous reset mid-cycle, held for n cycles with random (ignored) activity.
  task automatic do_reset(input int n);
    exp_t e;
    #2 rst_clk = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom));
      if (i == 0) alloc_req = 1'b1;
      e.full  = 1'b1;
      e.vld   = alloc_req && !y_idu_ir_stall_ctrl && !rtu_global_flush;
      e.preg  = 6'd32;
      e.cnt   = 6'd32;
      e.empty = 1'b0;
      e.err   = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 6'd0);
    rst_clk = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_clk = 1'b0;
    drive(0, 0, 0, 0, 6'd0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // Drain the whole list, then one more request against an empty list.
    for (int i = 0; i < 33; i++) step(1, 0, 0, 0, 6'd0);
    // Release into an empty list: not allocatable until the next cycle.
    step(1, 0, 0, 1, 6'd5);
    step(1, 0, 0, 0, 6'd0);

    // Speculative allocations rewound by flush, then reissued in order.
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 6'd0);
    step(0, 0, 0, 1, 6'd7);
    step(1, 0, 1, 0, 6'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 6'd0);
    step(1, 0, 1, 1, 6'd9);
    step(1, 0, 0, 0, 6'd0);

    // Stall blocks allocation but not retirement.
    do_reset(1);
    step(1, 0, 0, 0, 6'd0);
    step(1, 0, 0, 0, 6'd0);
    step(1, 1, 0, 0, 6'd0);
    step(1, 1, 0, 1, 6'd11);
    step(1, 1, 0, 0, 6'd0);
    step(1, 0, 0, 0, 6'd0);

    // Steady alloc+retire across many pointer wraps.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 6'd0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, 1, 6'($urandom));

`ifdef IDU_FREELIST_CHK_EN
    // Overflow retire at reset state sets the sticky error.
    do_reset(1);
    step(0, 0, 0, 1, 6'd40, 1'b0);
    for (int i = 0; i < 4; i++) step(1'($urandom), 0, 0, 0, 6'd0, 1'b0);
`endif

    // Randomized traffic with occasional flushes and mid-run resets.
    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      bit r, s, f, t;
      r = ($urandom_range(99) < 70);
      s = ($urandom_range(99) < 20);
      f = ($urandom_range(99) < 5);
      t = (spec_q.size() > 0) && ($urandom_range(99) < 45);
      if ($urandom_range(499) == 0) do_reset(1 + $urandom_range(2));
      else step(r, s, f, t, 6'($urandom));
    end

    @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
